// File: rtl/ccip_rd_requester.sv
// CCI-P host-memory read requester: issues num_lines reads on Tx c0 and streams Rx c0 lines out.
// Optional cycle counter on perf_cycles is built when CCIP_RD_PERF_CNT_EN is defined.
module ccip_rd_requester #(
    parameter int unsigned ADDR_W    = 42,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_OUTST = 16,
    parameter int unsigned DATA_W    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_lines,
    input  logic              c0TxAlmFull,
    output logic              tx_c0_valid,
    output logic [ADDR_W-1:0] tx_c0_addr,
    output logic [15:0]       tx_c0_mdata,
    input  logic              rx_c0_rspValid,
    input  logic [15:0]       rx_c0_mdata,
    input  logic [DATA_W-1:0] rx_c0_data,
    output logic              out_valid,
    output logic [15:0]       out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_cycles
);

    localparam int unsigned OutW = $clog2(MAX_OUTST) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    received_q, received_d;
    logic [OutW-1:0]     outst_q, outst_d;
    logic                tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]   tx_addr_q, tx_addr_d;
    logic [15:0]         tx_mdata_q, tx_mdata_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         out_idx_q, out_idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                done_q, done_d;

    logic start_acc;
    logic issue_go;
    logic rsp_cnt;

    assign start_acc = (state_q == StIdle) && start;
    // AlmFull is used combinationally so at most one request trails its assertion.
    assign issue_go  = (state_q == StIssue) && !c0TxAlmFull &&
                       (outst_q < OutW'(MAX_OUTST)) && (issued_q < len_q);
    // Responses outside ISSUE/DRAIN are strays: forwarded but never counted.
    assign rsp_cnt   = rx_c0_rspValid && ((state_q == StIssue) || (state_q == StDrain));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions look at the counts including this cycle's event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (num_lines == '0) ? StDone : StIssue;
            StIssue: if (issued_d == len_q) state_d = StDrain;
            StDrain: if (received_d == len_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q == StIssue) || (state_q == StDrain);
        done_d = (state_q == StDone);
    end

    // Datapath next-state
    always_comb begin
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        received_d  = received_q;
        outst_d     = outst_q;
        tx_valid_d  = issue_go;
        tx_addr_d   = tx_addr_q;
        tx_mdata_d  = tx_mdata_q;
        out_valid_d = rx_c0_rspValid;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;

        if (start_acc) begin
            base_d     = base_addr;
            len_d      = num_lines;
            issued_d   = '0;
            received_d = '0;
            outst_d    = '0;
        end

        if (issue_go) begin
            issued_d   = issued_q + 1'b1;
            tx_addr_d  = base_q + ADDR_W'(issued_q);
            tx_mdata_d = 16'(issued_q);
        end

        if (rsp_cnt) begin
            received_d = received_q + 1'b1;
        end

        if (issue_go && !rsp_cnt) begin
            outst_d = outst_q + 1'b1;
        end else if (!issue_go && rsp_cnt && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end

        if (rx_c0_rspValid) begin
            out_idx_d  = rx_c0_mdata;
            out_data_d = rx_c0_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            outst_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            outst_q     <= outst_d;
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign tx_c0_valid = tx_valid_q;
    assign tx_c0_addr  = tx_addr_q;
    assign tx_c0_mdata = tx_mdata_q;
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign out_data    = out_data_q;
    assign done        = done_q;

`ifdef CCIP_RD_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Cleared on accepted start, counts busy cycles, saturates, holds after done
    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
